// File: rtl/bk_addsub_pipe_pkg.sv
// Shared constants and types for the pipelined Brent-Kung adder/subtractor.
package bk_addsub_pipe_pkg;

  // Operand width. The prefix tree in the top module is wired for 16 bits.
  localparam int WIDTH = 16;

  // Pipeline depth in cycles (fixed by the three register stages).
  localparam int LATENCY = 3;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Group propagate/generate pair for one prefix-tree node.
  typedef struct packed {
    logic p;
    logic g;
  } gp_t;

endpackage

// File: rtl/bk_addsub_pipe_if.sv
// Operand/result bus of the pipelined Brent-Kung adder/subtractor.
//
// Handshake: an operand set transfers on a rising clk edge where In_Valid and
// In_Ready are both high; a result transfers on an edge where Out_Valid and
// Out_Ready are both high. A source holding valid high keeps its payload
// stable until the transfer; ready never depends on the valid of its own side.
interface bk_addsub_pipe_if;
  import bk_addsub_pipe_pkg::*;

  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Mode;
  logic             Carry_in;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic             Carry_Out;
  logic             Borrow;
  logic             Overflow;

  // Operand producer / result consumer side.
  modport master (
    output In_Valid, A, B, Mode, Carry_in, Out_Ready,
    input  In_Ready, Out_Valid, Result, Carry_Out, Borrow, Overflow
  );

  // Arithmetic block side.
  modport slave (
    input  In_Valid, A, B, Mode, Carry_in, Out_Ready,
    output In_Ready, Out_Valid, Result, Carry_Out, Borrow, Overflow
  );

endinterface

// File: rtl/bk_gp_cell.sv
// Group generate/propagate combine cell: (hi) o (lo).
module bk_gp_cell
  import bk_addsub_pipe_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t grp
);

  // Span of hi extended downward by lo.
  always_comb begin
    grp.p = hi.p & lo.p;
    grp.g = hi.g | (hi.p & lo.g);
  end

endmodule

// File: rtl/bk_addsub_pipe.sv
// 16-bit three-stage Brent-Kung adder/subtractor with valid/ready flow control.
// Stage 1 forms bitwise P/G, stage 2 runs the up-sweep, stage 3 runs the
// down-sweep and forms sum, carry, borrow and signed overflow.
module bk_addsub_pipe
  import bk_addsub_pipe_pkg::*;
(
  input logic             clk,
  input logic             rst,
  bk_addsub_pipe_if.slave bus
);

  localparam int HALF = WIDTH / 2;

  // Stage 1: bitwise propagate/generate.
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic             cin1_q, cin1_d;
  logic             mode1_q, mode1_d;

  // Stage 2: bit P, generate of odd bit positions (even-position generates
  // already live inside the up-sweep groups), and the up-sweep groups.
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [HALF-1:0]  godd2_q, godd2_d;
  gp_t  [HALF-1:0]  up2_q, up2_d;
  logic             cin2_q, cin2_d;
  logic             mode2_q, mode2_d;

  // Stage 3: registered result.
  logic             v3_q, v3_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;

  logic adv1, adv2, in_ready;

  // Advance chain: a stage may load when its successor is empty or moving.
  always_comb begin
    adv2     = ~v3_q | bus.Out_Ready;
    adv1     = ~v2_q | adv2;
    in_ready = ~v1_q | adv1;
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = v3_q;
  assign bus.Result    = result_q;
  assign bus.Carry_Out = carry_out_q;
  assign bus.Borrow    = borrow_q;
  assign bus.Overflow  = overflow_q;

  // Stage 1 capture: subtract becomes A + ~B + 1.
  logic [WIDTH-1:0] b_eff;
  always_comb begin
    b_eff   = (bus.Mode == MODE_SUB) ? ~bus.B : bus.B;
    v1_d    = v1_q;
    p1_d    = p1_q;
    g1_d    = g1_q;
    cin1_d  = cin1_q;
    mode1_d = mode1_q;
    if (in_ready) begin
      v1_d = bus.In_Valid;
      if (bus.In_Valid) begin
        p1_d    = bus.A ^ b_eff;
        g1_d    = bus.A & b_eff;
        cin1_d  = (bus.Mode == MODE_SUB) ? 1'b1 : bus.Carry_in;
        mode1_d = bus.Mode;
      end
    end
  end

  // Up-sweep: spans 2, 4, 8 and 16 ending at even bit positions.
  gp_t s2n [HALF];
  gp_t s4n [4];
  gp_t s8n [2];
  gp_t s16;

  for (genvar j = 0; j < HALF; j++) begin : g_span2
    bk_gp_cell u_cell (
      .hi  ({p1_q[2*j+1], g1_q[2*j+1]}),
      .lo  ({p1_q[2*j],   g1_q[2*j]}),
      .grp (s2n[j])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_span4
    bk_gp_cell u_cell (.hi(s2n[2*j+1]), .lo(s2n[2*j]), .grp(s4n[j]));
  end

  for (genvar j = 0; j < 2; j++) begin : g_span8
    bk_gp_cell u_cell (.hi(s4n[2*j+1]), .lo(s4n[2*j]), .grp(s8n[j]));
  end

  bk_gp_cell u_span16 (.hi(s8n[1]), .lo(s8n[0]), .grp(s16));

  // Final up-sweep group per even position: entry j covers position 2j+2.
  gp_t [HALF-1:0] up_now;
  always_comb begin
    up_now[0] = s2n[0];  // [2:1]
    up_now[1] = s4n[0];  // [4:1]
    up_now[2] = s2n[2];  // [6:5]
    up_now[3] = s8n[0];  // [8:1]
    up_now[4] = s2n[4];  // [10:9]
    up_now[5] = s4n[2];  // [12:9]
    up_now[6] = s2n[6];  // [14:13]
    up_now[7] = s16;     // [16:1]
  end

  // Stage 2 load.
  always_comb begin
    v2_d    = v2_q;
    p2_d    = p2_q;
    godd2_d = godd2_q;
    up2_d   = up2_q;
    cin2_d  = cin2_q;
    mode2_d = mode2_q;
    if (adv1) begin
      v2_d = v1_q;
      if (v1_q) begin
        p2_d = p1_q;
        for (int k = 0; k < HALF; k++) begin
          godd2_d[k] = g1_q[2*k];
        end
        up2_d   = up_now;
        cin2_d  = cin1_q;
        mode2_d = mode1_q;
      end
    end
  end

  // Down-sweep: pre[k] is the group [k+1:1].
  gp_t pre [WIDTH];

  assign pre[0]  = {p2_q[0], godd2_q[0]};
  assign pre[1]  = up2_q[0];
  assign pre[3]  = up2_q[1];
  assign pre[7]  = up2_q[3];
  assign pre[15] = up2_q[7];

  bk_gp_cell u_pre6  (.hi(up2_q[2]), .lo(up2_q[1]), .grp(pre[5]));
  bk_gp_cell u_pre10 (.hi(up2_q[4]), .lo(up2_q[3]), .grp(pre[9]));
  bk_gp_cell u_pre12 (.hi(up2_q[5]), .lo(up2_q[3]), .grp(pre[11]));
  bk_gp_cell u_pre14 (.hi(up2_q[6]), .lo(pre[11]),  .grp(pre[13]));

  for (genvar k = 1; k < HALF; k++) begin : g_odd
    bk_gp_cell u_cell (
      .hi  ({p2_q[2*k], godd2_q[k]}),
      .lo  (pre[2*k-1]),
      .grp (pre[2*k])
    );
  end

  // Carries, sum and stage 3 load.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  always_comb begin
    c[0] = cin2_q;
    for (int k = 0; k < WIDTH; k++) begin
      c[k+1] = pre[k].g | (cin2_q & pre[k].p);
    end
    sum         = p2_q ^ c[WIDTH-1:0];
    v3_d        = v3_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    borrow_d    = borrow_q;
    overflow_d  = overflow_q;
    if (adv2) begin
      v3_d = v2_q;
      if (v2_q) begin
        result_d    = sum;
        carry_out_d = c[WIDTH];
        overflow_d  = c[WIDTH] ^ c[WIDTH-1];
        borrow_d    = (mode2_q == MODE_SUB) & ~c[WIDTH];
      end
    end
  end

  // All pipeline state; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      p1_q        <= '0;
      g1_q        <= '0;
      cin1_q      <= 1'b0;
      mode1_q     <= 1'b0;
      v2_q        <= 1'b0;
      p2_q        <= '0;
      godd2_q     <= '0;
      up2_q       <= '0;
      cin2_q      <= 1'b0;
      mode2_q     <= 1'b0;
      v3_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      p1_q        <= p1_d;
      g1_q        <= g1_d;
      cin1_q      <= cin1_d;
      mode1_q     <= mode1_d;
      v2_q        <= v2_d;
      p2_q        <= p2_d;
      godd2_q     <= godd2_d;
      up2_q       <= up2_d;
      cin2_q      <= cin2_d;
      mode2_q     <= mode2_d;
      v3_q        <= v3_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      borrow_q    <= borrow_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
